// File: rtl/prior_buffer_pkg.sv
// Shared types and constant helpers for the multi-lane prior buffer.
package prior_buffer_pkg;

    typedef enum logic [1:0] {
        PB_IDLE    = 2'd0,
        PB_COLLECT = 2'd1,
        PB_HOLD    = 2'd2
    } pb_state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int pb_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Keeps only the low w bits of a reset value.
    function automatic logic [63:0] pb_limit(input logic [63:0] v, input int w);
        if (w >= 64) begin
            return v;
        end
        return v & ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/prior_buffer_lane_sel.sv
// Combinational compaction: maps qualified lanes, in ascending index order,
// onto consecutive slot offsets, limited by the remaining capacity.
module prior_buffer_lane_sel
    import prior_buffer_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int IDX_W = (LANES > 1) ? pb_clog2(LANES) : 1,
    parameter int CNT_W = pb_clog2(DEPTH + 1)
) (
    input  logic [LANES-1:0] mask,
    input  logic [CNT_W-1:0] rem,
    output logic [IDX_W-1:0] sel_idx [DEPTH],
    output logic [CNT_W-1:0] take,
    output logic             drop
);

    int pre [LANES];
    int pop;

    // pre[i] is the offset lane i would land on if it is qualified.
    always_comb begin
        int run;
        run = 0;
        for (int i = 0; i < LANES; i++) begin
            pre[i] = run;
            if (mask[i]) begin
                run = run + 1;
            end
        end
        pop = run;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_off
            logic [IDX_W-1:0] idx;
            always_comb begin
                idx = '0;
                for (int i = 0; i < LANES; i++) begin
                    if (mask[i] && pre[i] == gi) begin
                        idx = IDX_W'(i);
                    end
                end
            end
            assign sel_idx[gi] = idx;
        end
    endgenerate

    always_comb begin
        take = CNT_W'((pop < int'(rem)) ? pop : int'(rem));
        drop = (pop > int'(rem));
    end

endmodule

// File: rtl/prior_buffer_n.sv
// Multi-lane first-DEPTH-valid capture buffer over an init/done window.
// Optional sticky drop indication via macro PRIOR_BUFFER_N_OVF_EN (adds out_ovf).
module prior_buffer_n
    import prior_buffer_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter int          LANES   = 4,
    parameter int          DEPTH   = 4,
    parameter logic [31:0] RST_VAL = '0,
    localparam int         CNT_W   = pb_clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   in_ctr_Srst,
    input  logic                   in_ctr_en,
    input  logic                   in_ctr_init,
    input  logic                   in_ctr_done,
    input  logic                   in_ctr_buf_en,
    input  logic [LANES-1:0]       in_ctr_valid,
    input  logic [LANES*WIDTH-1:0] in,
    output logic [DEPTH*WIDTH-1:0] out,
    output logic [CNT_W-1:0]       out_cnt,
    output logic                   out_full,
    output logic                   out_closed
`ifdef PRIOR_BUFFER_N_OVF_EN
    ,
    output logic                   out_ovf
`endif
);

    localparam int              IDX_W = (LANES > 1) ? pb_clog2(LANES) : 1;
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(pb_limit(64'(RST_VAL), WIDTH));

    pb_state_t        state_reg;
    logic [WIDTH-1:0] slot_reg [DEPTH];
    logic [CNT_W-1:0] cnt_reg;
    logic             closed_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] lane_w  [LANES];
    logic [IDX_W-1:0] sel_idx [DEPTH];
    logic [WIDTH-1:0] wr_data [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic [LANES-1:0] mask;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] take;
    logic             drop_w;

    assign mask = in_ctr_valid & {LANES{in_ctr_buf_en}};
    assign rem  = CNT_W'(DEPTH) - cnt_reg;

    prior_buffer_lane_sel #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_lane_sel (
        .mask    (mask),
        .rem     (rem),
        .sel_idx (sel_idx),
        .take    (take),
        .drop    (drop_w)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_w[gi] = in[gi*WIDTH +: WIDTH];
        end

        // Slot gi receives the word at offset (gi - count) of this cycle's takes.
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic             en_l;
            logic [WIDTH-1:0] data_l;
            always_comb begin
                int off;
                off    = gi - int'(cnt_reg);
                en_l   = 1'b0;
                data_l = lane_w[0];
                if (off >= 0 && off < int'(take)) begin
                    en_l   = 1'b1;
                    data_l = lane_w[sel_idx[off]];
                end
            end
            assign wr_en[gi]   = en_l;
            assign wr_data[gi] = data_l;
            assign out[gi*WIDTH +: WIDTH] = slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            state_reg  <= PB_IDLE;
            cnt_reg    <= '0;
            closed_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_reg[k] <= RST_W;
            end
        end else if (in_ctr_en) begin
            // init wins over done and discards the same-cycle valids.
            if (in_ctr_init) begin
                state_reg  <= PB_COLLECT;
                cnt_reg    <= '0;
                closed_reg <= 1'b0;
                ovf_reg    <= 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    slot_reg[k] <= RST_W;
                end
            end else begin
                case (state_reg)
                    PB_COLLECT: begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (wr_en[k]) begin
                                slot_reg[k] <= wr_data[k];
                            end
                        end
                        cnt_reg <= cnt_reg + take;
                        ovf_reg <= ovf_reg | drop_w;
                        if (in_ctr_done) begin
                            state_reg  <= PB_HOLD;
                            closed_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_cnt    = cnt_reg;
    assign out_full   = (cnt_reg == CNT_W'(DEPTH));
    assign out_closed = closed_reg;

`ifdef PRIOR_BUFFER_N_OVF_EN
    assign out_ovf = ovf_reg;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_reg ^ drop_w;
`endif

endmodule

// File: doc/prior_buffer_n.md
Name: prior_buffer_n

Overview:
- Multi-lane, multi-entry successor of the single-entry first-valid prior buffer in the 62_buffer group.
- During a search window bounded by init and done, it captures the first DEPTH valid words in arrival order. Within one cycle, a lower lane index has higher priority.
- Used after the parallel Chien-search stage to collect up to DEPTH error locations. Presents them with a count, a full flag and a window-closed indication to the correction stage.

Parameters:
- WIDTH, 8, bits per data word.
- LANES, 4, input words offered per cycle (1..16).
- DEPTH, 4, stored entries (1..16).
- RST_VAL, 0, value shown in unfilled slots and after reset; truncated to WIDTH bits.
- CNT_W, clog2(DEPTH+1), localparam, width of out_cnt.

Ports:
- clk  in  1  clock.
- in_ctr_Srst  in  1  synchronous active-high reset.
- in_ctr_en  in  1  global enable; when low, all state is frozen.
- in_ctr_init  in  1  opens a new window: clears slots, count and flags.
- in_ctr_done  in  1  closes the current window.
- in_ctr_buf_en  in  1  qualifies in_ctr_valid; valids are ignored when low.
- in_ctr_valid  in  LANES  per-lane valid.
- in  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- out  out  DEPTH*WIDTH  slot k occupies bits [k*WIDTH +: WIDTH]; slot 0 holds the earliest capture.
- out_cnt  out  CNT_W  number of filled slots.
- out_full  out  1  out_cnt == DEPTH.
- out_closed  out  1  window closed; out/out_cnt are final.

Behaviour:
- Reset (in_ctr_Srst=1, any cycle, overrides all other inputs): state IDLE, all slots RST_VAL, out_cnt 0, out_full 0, out_closed 0. Reset mid-window discards all captures.
- States: IDLE, COLLECT, HOLD. All transitions below require in_ctr_en=1.
- IDLE:
  - init -> COLLECT, clearing slots and count.
  - Valids are ignored.
  - done is ignored.
- COLLECT:
  - Capture is qualified by buf_en & valid[i].
  - Let R = DEPTH - out_cnt. Take the first min(R, popcount) qualified lanes in ascending lane index.
  - Write them to slots out_cnt, out_cnt+1, ... in the same clock edge.
  - out_cnt increments by the number taken. Excess valids are dropped.
  - Once full, further valids are dropped and the state remains COLLECT.
  - done -> HOLD, out_closed=1 next cycle. Valids qualified in the done cycle are still captured.
- HOLD:
  - Slots are frozen and valids are ignored.
  - init -> COLLECT with a clear; out_closed=0 next cycle.
- Simultaneous events:
  - init beats done in any state.
  - init together with valid: the window is cleared and the valids of that cycle are NOT captured. The first capture is possible on the next cycle.
- Latency: registered only. A capture is visible on out/out_cnt one cycle after the valid edge. There is no combinational path from in to out.
- Empty window: done with out_cnt=0 -> all slots remain RST_VAL, out_closed=1. This generalises the single-entry behaviour of "done without valid gives RST_VAL".
- Unfilled slots always read RST_VAL.
- in_ctr_en low freezes state, slots, count and flags, regardless of init, done or valid.

Optional Feature:
- Macro PRIOR_BUFFER_N_OVF_EN.
- Defined:
  - Adds output out_ovf (1 bit), sticky per window: set when any qualified valid is dropped because capacity is exhausted, including partial drops within one cycle.
  - Cleared by init and by reset. Registered, same timing as out_cnt.
- Undefined: the port and its logic are absent; drops are silent.

Decomposition:
- Shared package prior_buffer_pkg:
  - state encoding constants PB_IDLE=2'd0, PB_COLLECT=2'd1, PB_HOLD=2'd2;
  - clog2 function;
  - WIDTH-limiting function for RST_VAL.
- Sub-module prior_buffer_lane_sel: purely combinational compaction. Takes valid mask, lanes and remaining capacity R. Outputs per-slot-offset lane index, take count and drop flag. Instantiated once.

Test Plan (WIDTH=8, LANES=4, DEPTH=4, RST_VAL=0):
- Reset, then init. Cycle 1: valid=4'b1010, in lanes={0x44,0x33,0x22,0x11}. Then done. -> slots {0x22,0x44,0,0} (slot 0 first), out_cnt=2, out_closed=1 one cycle after done.
- Overflow: valid=4'b0111 ({.., 0x03,0x02,0x01}) then valid=4'b1111 ({0x0D,0x0C,0x0B,0x0A}). -> slots {0x01,0x02,0x03,0x0A}, out_full=1, out_ovf=1 when the macro is defined.
- init+valid=4'b0001 in the same cycle, then done with no valid. -> out_cnt=0, all slots 0, out_closed=1.
- Valids with buf_en=0, and valids while en=0, during COLLECT. -> no change to slots or out_cnt. en low across a done edge: out_closed stays 0.
- Srst asserted mid-COLLECT with out_cnt=3. -> next cycle out_cnt=0, slots 0, state IDLE; a following done alone leaves out_closed=0.
- done with valid=4'b0100 (0x5A) in the same cycle. -> 0x5A captured in slot out_cnt, out_closed=1. Subsequent valids in HOLD are ignored until the next init.
